// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the exec_sequencer slice: instruction field layout,
// condition encodings, FSM state type and the halt/watchdog constants.
package exec_sequencer_pkg;

  localparam int COND_HI   = 15;
  localparam int COND_LO   = 14;
  localparam int OP_HI     = 13;
  localparam int OP_LO     = 10;
  localparam int DEST_HI   = 9;
  localparam int DEST_LO   = 7;
  localparam int SRC1_HI   = 6;
  localparam int SRC1_LO   = 4;
  localparam int SRC2_HI   = 3;
  localparam int SRC2_LO   = 1;
  localparam int SHIFT_BIT = 0;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'b00,
    COND_Z      = 2'b01,
    COND_NZ     = 2'b10,
    COND_C      = 2'b11
  } cond_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [3:0] HALT_OP  = 4'hF;
  localparam logic [7:0] WDOG_MAX = 8'd255;

endpackage

// File: rtl/exec_sequencer_cond_check.sv
// Combinational condition evaluator: decides whether an instruction executes
// given its cond field and the current Z/C flags.
module cond_check
  import exec_sequencer_pkg::*;
(
  input  logic [1:0] cond,
  input  logic       z,
  input  logic       c,
  output logic       take
);

  // NOTE: every combinational output gets a default before the case so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    take = 1'b0;
    case (cond_e'(cond))
      COND_ALWAYS: take = 1'b1;
      COND_Z:      take = z;
      COND_NZ:     take = ~z;
      COND_C:      take = c;
    endcase
  end

endmodule

// File: rtl/exec_sequencer.sv
// Instruction execution sequencer: accepts one instruction at a time, checks
// its condition, drives the ALU, guards it with a watchdog and strobes writeback.
// Optional retire/skip performance counters are enabled by EXEC_SEQUENCER_PERF_EN.
module exec_sequencer
  import exec_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  input  logic [15:0] inst,
  output logic        inst_ready,
  output logic        alu_start,
  output logic [3:0]  alu_op,
  output logic [2:0]  alu_dest,
  output logic [2:0]  alu_src1,
  output logic [2:0]  alu_src2,
  output logic        alu_shift,
  input  logic        alu_done,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic        rf_we,
  output logic        skipped,
  output logic        halted,
  output logic        timeout_err
`ifdef EXEC_SEQUENCER_PERF_EN
  ,
  output logic [15:0] retired_cnt,
  output logic [15:0] skip_cnt
`endif
);

  state_e      state, state_nxt;
  logic [15:0] inst_q;
  logic        z_q, c_q;
  logic [7:0]  wdog_q;
  logic        timeout_q;
  logic        take;
  logic        wdog_expired;

  cond_check u_cond_check (
    .cond (inst_q[COND_HI:COND_LO]),
    .z    (z_q),
    .c    (c_q),
    .take (take)
  );

  // Held fields come straight from the captured word, so they stay stable
  // from alu_start until a new instruction is accepted.
  assign alu_op      = inst_q[OP_HI:OP_LO];
  assign alu_dest    = inst_q[DEST_HI:DEST_LO];
  assign alu_src1    = inst_q[SRC1_HI:SRC1_LO];
  assign alu_src2    = inst_q[SRC2_HI:SRC2_LO];
  assign alu_shift   = inst_q[SHIFT_BIT];
  assign timeout_err = timeout_q;

  assign wdog_expired = (wdog_q == WDOG_MAX);

  always_comb begin
    state_nxt  = state;
    inst_ready = 1'b0;
    alu_start  = 1'b0;
    rf_we      = 1'b0;
    skipped    = 1'b0;
    halted     = 1'b0;
    case (state)
      S_IDLE: begin
        inst_ready = 1'b1;
        if (inst_valid) state_nxt = S_EVAL;
      end
      S_EVAL: begin
        if (!take) begin
          skipped   = 1'b1;
          state_nxt = S_IDLE;
        end else if (alu_op == HALT_OP) begin
          state_nxt = S_HALT;
        end else begin
          alu_start = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      // A late alu_done on the final watchdog count still completes normally.
      S_EXEC: begin
        if (alu_done)          state_nxt = S_WB;
        else if (wdog_expired) state_nxt = S_IDLE;
      end
      S_WB: begin
        rf_we     = 1'b1;
        state_nxt = S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q    <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (inst_ready && inst_valid) inst_q <= inst;
      if (alu_start) wdog_q <= '0;
      if (state == S_EXEC) begin
        if (alu_done) begin
          z_q <= alu_zero;
          c_q <= alu_carry;
        end else if (wdog_expired) begin
          timeout_q <= 1'b1;
        end else begin
          wdog_q <= wdog_q + 8'd1;
        end
      end
    end
  end

`ifdef EXEC_SEQUENCER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      skip_cnt    <= '0;
    end else begin
      if (rf_we)   retired_cnt <= retired_cnt + 16'd1;
      if (skipped) skip_cnt    <= skip_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomized scoreboard bench for exec_sequencer: a behavioural model queues
// expected ALU/skip/halt/writeback/timeout events; a monitor pops and compares.
module tb_exec_sequencer;

  localparam int EV_START   = 1;
  localparam int EV_SKIP    = 2;
  localparam int EV_WB      = 3;
  localparam int EV_HALT    = 4;
  localparam int EV_TIMEOUT = 5;

  typedef struct {
    int         kind;
    logic [3:0] op;
    logic [2:0] dest;
    logic [2:0] src1;
    logic [2:0] src2;
    logic       shift;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid;
  logic [15:0] inst;
  logic        inst_ready;
  logic        alu_start;
  logic [3:0]  alu_op;
  logic [2:0]  alu_dest, alu_src1, alu_src2;
  logic        alu_shift;
  logic        alu_done, alu_zero, alu_carry;
  logic        rf_we, skipped, halted, timeout_err;
`ifdef EXEC_SEQUENCER_PERF_EN
  logic [15:0] retired_cnt, skip_cnt;
`endif

  exec_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_ready  (inst_ready),
    .alu_start   (alu_start),
    .alu_op      (alu_op),
    .alu_dest    (alu_dest),
    .alu_src1    (alu_src1),
    .alu_src2    (alu_src2),
    .alu_shift   (alu_shift),
    .alu_done    (alu_done),
    .alu_zero    (alu_zero),
    .alu_carry   (alu_carry),
    .rf_we       (rf_we),
    .skipped     (skipped),
    .halted      (halted),
    .timeout_err (timeout_err)
`ifdef EXEC_SEQUENCER_PERF_EN
    ,
    .retired_cnt (retired_cnt),
    .skip_cnt    (skip_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  ev_t  exp_q[$];

  // Reference state: architectural flags, sticky error and retire/skip totals.
  bit          mz, mc, m_to;
  logic [15:0] m_retired, m_skips;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit model_take(input logic [1:0] cond);
    if (cond == 2'd0) return 1'b1;
    if (cond == 2'd1) return mz;
    if (cond == 2'd2) return !mz;
    return mc;
  endfunction

  function automatic ev_t mk_ev(input int kind, input logic [15:0] w);
    ev_t e;
    e.kind  = kind;
    e.op    = w[13:10];
    e.dest  = w[9:7];
    e.src1  = w[6:4];
    e.src2  = w[3:1];
    e.shift = w[0];
    return e;
  endfunction

  // ---------------- monitor ----------------
  ev_t mon_e;
  bit  halted_d, to_d;

  task automatic pop_ev(input int kind_seen, output ev_t e);
    if (exp_q.size() == 0) begin
      e.kind = 0;
      check("unexpected_event", kind_seen, 0);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind_seen, e.kind);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      halted_d = 1'b0;
      to_d     = 1'b0;
    end else begin
      if (alu_start) begin
        pop_ev(EV_START, mon_e);
        if (mon_e.kind == EV_START)
          check("alu_fields", {alu_op, alu_dest, alu_src1, alu_src2, alu_shift},
                {mon_e.op, mon_e.dest, mon_e.src1, mon_e.src2, mon_e.shift});
      end
      if (skipped)                 pop_ev(EV_SKIP, mon_e);
      if (rf_we)                   pop_ev(EV_WB, mon_e);
      if (halted && !halted_d)     pop_ev(EV_HALT, mon_e);
      if (timeout_err && !to_d)    pop_ev(EV_TIMEOUT, mon_e);
      halted_d = halted;
      to_d     = timeout_err;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n      = 1'b0;
    inst_valid = 1'b0;
    alu_done   = 1'b0;
    #2;
    check("reset_outputs",
          {alu_start, rf_we, skipped, halted, timeout_err,
           alu_op, alu_dest, alu_src1, alu_src2, alu_shift}, 0);
`ifdef EXEC_SEQUENCER_PERF_EN
    check("reset_perf", {retired_cnt, skip_cnt}, 0);
`endif
    check("queue_empty_at_reset", exp_q.size(), 0);
    exp_q.delete();
    mz = 0; mc = 0; m_to = 0; m_retired = '0; m_skips = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", inst_ready, 1);
  endtask

  task automatic wait_ready(input int bound, output int cycles);
    cycles = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      cycles = i;
      if (inst_ready) break;
    end
    if (!inst_ready) check("ready_wait_expired", 0, 1);
  endtask

  // k >= 0: alu_done in EXEC cycle k; k == -1: never done; k == -2: abandon
  // five cycles into EXEC (caller resets).
  task automatic issue(input logic [15:0] w, input int k, input bit zf, input bit cf,
                       input bit spur);
    bit take;
    int n;
    @(negedge clk);
    check("ready_before_issue", inst_ready, 1);
    inst       = w;
    inst_valid = 1'b1;
    if (spur) begin
      alu_done  = 1'b1;
      alu_zero  = 1'($urandom);
      alu_carry = 1'($urandom);
    end
    @(posedge clk); #1;
    inst_valid = 1'b0;
    inst       = 16'($urandom);
    take = model_take(w[15:14]);
    if (!take) begin
      exp_q.push_back(mk_ev(EV_SKIP, w));
      m_skips++;
      check("skip_pulse", {skipped, alu_start}, 2'b10);
      @(posedge clk); #1;
      alu_done = 1'b0;
      check("ready_after_skip", inst_ready, 1);
    end else if (w[13:10] == 4'hF) begin
      exp_q.push_back(mk_ev(EV_HALT, w));
      @(posedge clk); #1;
      alu_done = 1'b0;
      check("halt_state", {halted, inst_ready}, 2'b10);
    end else begin
      exp_q.push_back(mk_ev(EV_START, w));
      check("start_in_eval", alu_start, 1);
      @(posedge clk); #1;
      alu_done = 1'b0;
      if (k >= 0) begin
        repeat (k) @(posedge clk) #1;
        alu_done  = 1'b1;
        alu_zero  = zf;
        alu_carry = cf;
        exp_q.push_back(mk_ev(EV_WB, w));
        mz = zf; mc = cf;
        m_retired++;
        @(posedge clk); #1;
        alu_done = 1'b0;
        check("rf_we_in_wb", rf_we, 1);
        @(posedge clk); #1;
        check("ready_after_wb", {inst_ready, rf_we}, 2'b10);
      end else if (k == -1) begin
        if (!m_to) exp_q.push_back(mk_ev(EV_TIMEOUT, w));
        m_to = 1'b1;
        wait_ready(400, n);
        check("timeout_latency", n, 257);
        check("timeout_err_set", timeout_err, 1);
      end else begin
        repeat (5) @(posedge clk);
      end
    end
  endtask

  logic [15:0] w;
  int          k;
  bit          spurious;

  initial begin
    rst_n = 1'b0; inst_valid = 1'b0; inst = '0;
    alu_done = 1'b0; alu_zero = 1'b0; alu_carry = 1'b0;
    do_reset();

    // Basic op, alu_done two cycles after alu_start; then minimum latency.
    issue(16'h0452, 1, 1'b0, 1'b1, 1'b0);
    issue(16'h0452, 0, 1'b0, 1'b0, 1'b1);
    // Z=0: cond Z skips, for a normal op and for the halt opcode.
    issue(16'h4452, 0, 1'b0, 1'b0, 1'b1);
    issue(16'h7C00, 0, 1'b0, 1'b0, 1'b0);
    // Cond NZ and C paths.
    issue(16'h8A5B, 0, 1'b1, 1'b1, 1'b0);
    issue(16'hC8F1, 2, 1'b0, 1'b0, 1'b0);
    issue(16'h8A5B, 0, 1'b0, 1'b0, 1'b0);
    // alu_done on the last watchdog count wins.
    issue(16'h1A2C, 255, 1'b1, 1'b0, 1'b0);
    // Watchdog expiry, flags kept; next instruction runs normally.
    issue(16'h0C33, -1, 1'b0, 1'b0, 1'b0);
    issue(16'h4C33, 0, 1'b0, 1'b1, 1'b0);
    issue(16'hC0FF, 0, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      w = 16'($urandom);
      if (w[13:10] == 4'hF && model_take(w[15:14])) w[13:10] = 4'hE;
      k = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 5));
      spurious = 1'($urandom);
      issue(w, k, 1'($urandom), 1'($urandom), spurious);
    end
    issue(16'h2491, -1, 1'b0, 1'b0, 1'b0);
`ifdef EXEC_SEQUENCER_PERF_EN
    check("retired_cnt", retired_cnt, m_retired);
    check("skip_cnt", skip_cnt, m_skips);
`endif

    // Three retirements, then reset in the middle of EXEC.
    do_reset();
    for (int i = 0; i < 3; i++) issue(16'h0452, i, 1'b0, 1'b0, 1'b0);
`ifdef EXEC_SEQUENCER_PERF_EN
    check("retired_three", retired_cnt, 3);
`endif
    issue(16'h0A11, -2, 1'b0, 1'b0, 1'b0);
    do_reset();
    repeat (6) @(negedge clk);
    check("idle_after_abort", {inst_ready, rf_we, timeout_err}, 3'b100);
    issue(16'h0452, 1, 1'b1, 1'b0, 1'b0);

    // Halt, then further requests are ignored until reset.
    issue(16'h3C00, 0, 1'b0, 1'b0, 1'b0);
    inst_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inst = 16'($urandom);
      @(negedge clk);
      check("halt_holds", {halted, inst_ready}, 2'b10);
    end
    inst_valid = 1'b0;
    do_reset();
    issue(16'h0452, 0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset; ports listed below, clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 inst_valid  input  1  instruction word available from fetch side.
REQ-005 inst  input  16  instruction: cond[15:14], op[13:10], dest[9:7], src1[6:4], src2[3:1], shift[0].
REQ-006 inst_ready  output  1  block can accept an instruction; transfer when inst_valid and inst_ready are both high.
REQ-007 alu_start  output  1  one-cycle pulse launching the ALU.
REQ-008 alu_op  output  4  opcode held from alu_start until return to IDLE.
REQ-009 alu_dest, alu_src1, alu_src2  output  3 each  register indices, held like alu_op.
REQ-010 alu_shift  output  1  shift bit, held like alu_op.
REQ-011 alu_done  input  1  ALU result valid; sampled only in EXEC.
REQ-012 alu_zero, alu_carry  input  1 each  ALU flags, valid with alu_done.
REQ-013 rf_we  output  1  one-cycle register-file write strobe.
REQ-014 skipped  output  1  one-cycle pulse: instruction discarded by its condition.
REQ-015 halted  output  1  high in HALT state.
REQ-016 timeout_err  output  1  sticky ALU-timeout flag.

Function
REQ-017 The FSM SHALL have states IDLE, EVAL, EXEC, WB, HALT.
REQ-018 IDLE: inst_ready=1; on transfer, register inst and go to EVAL; else stay.
REQ-019 EVAL: inst_ready=0; evaluate cond against the Z and C flag registers: 00 always, 01 Z=1, 10 Z=0, 11 C=1.
REQ-020 EVAL with op=4'hF and cond true SHALL go to HALT without alu_start.
REQ-021 EVAL with cond false SHALL pulse skipped, issue no alu_start, and return to IDLE. This applies to every opcode, including 4'hF.
REQ-022 EVAL with cond true and op!=4'hF SHALL pulse alu_start, clear the watchdog counter and go to EXEC.
REQ-023 EXEC: on alu_done, load Z<=alu_zero and C<=alu_carry, then go to WB. alu_done outside EXEC SHALL be ignored.
REQ-024 WB: rf_we=1 for exactly one cycle, then IDLE.
REQ-025 Minimum latency: transfer in cycle 0, alu_start in cycle 1, alu_done accepted from cycle 2, rf_we in cycle 3, inst_ready high in cycle 4.
REQ-026 The 8-bit watchdog SHALL increment each EXEC cycle without alu_done.
REQ-027 At count 255 without alu_done, the watchdog SHALL set timeout_err, leave flags unchanged, skip rf_we and return to IDLE.
REQ-028 alu_done in the same cycle as count 255 SHALL win: normal completion, no error.
REQ-029 HALT: inst_ready=0, halted=1, exit only by reset.

Reset
REQ-030 While rst_n is low: state=IDLE, Z=C=0, watchdog=0, timeout_err=0; inst register and held fields=0; alu_start, rf_we, skipped, halted=0; inst_ready=1 once rst_n is high.
REQ-031 Reset asserted mid-EXEC SHALL abandon the instruction with no rf_we after release.

Configuration
REQ-032 Macro EXEC_SEQUENCER_PERF_EN present: add outputs retired_cnt[15:0] (+1 per WB) and skip_cnt[15:0] (+1 per skipped). Both counters reset to 0 and wrap 16'hFFFF->0.
REQ-033 Macro absent: no counters and no such ports; all other behaviour is identical.

Structure
REQ-034 A shared package SHALL hold the field bit positions, the cond encodings, the state enum, HALT_OP=4'hF and WDOG_MAX=8'd255.
REQ-035 Sub-module cond_check SHALL be combinational: cond, Z, C in -> take out.

Verification
REQ-036 After reset, inst=16'h0452 (cond 00, op 1, dest 0, src1 5, src2 1, shift 0), alu_done 2 cycles after start -> alu_start cycle 1, alu_op=1, alu_src1=5, rf_we exactly once.
REQ-037 Z=0 after prior op, inst cond=01 -> skipped pulse, no alu_start, inst_ready high 2 cycles after transfer.
REQ-038 inst=16'h3C00 (cond 00, op F) -> halted=1, inst_ready=0; further inst_valid ignored until rst_n pulse.
REQ-039 alu_done never asserted -> timeout_err=1 after 255 EXEC cycles, no rf_we, return to IDLE; next instruction executes normally.
REQ-040 rst_n low during EXEC -> all outputs at reset values; with EXEC_SEQUENCER_PERF_EN, retired_cnt=0 after 3 retired ops then reset.
